// File: rtl/m24_bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// m24_bus_arbiter_if
//
// Groups every signal between the M24C08 bus arbiter, its two EEPROM
// requesters and the top-level IOBUF into one bundle. Signal names keep the
// board-level names so they can be traced directly to the pin list.
//
// Modports:
//   slave  - the arbiter: samples requests and requester pin drives, drives
//            grants, the physical pin controls and status.
//   master - the surrounding logic (requesters, IOBUF, testbench): drives
//            requests, requester pin drives, the tick and the SDA pin value.
//
// Signals:
//   PULSE5uS_IN                  one-cycle tick every 5 us
//   REQ0_IN / REQ1_IN            level bus requests
//   GNT0_OUT / GNT1_OUT          level bus grants (never both high)
//   SCLn_IN / SDAn_IN / SDATn_IN requester pin drives (SDAT = 1 releases SDA)
//   SDA0_OUT / SDA1_OUT          SDA pin value returned to each requester
//   M24C08_SCL_OUT               SCL pin
//   M24C08_SDA_OUT               SDA output value
//   M24C08_SDAT_OUT              SDA tristate control, 1 = released
//   M24C08_SDA_IN                SDA pin value
//   BUSY_OUT                     arbiter not idle
//   TIMEOUT_OUT                  one-cycle pulse on hold watchdog expiry
// -----------------------------------------------------------------------------
interface m24_bus_arbiter_if;
  logic PULSE5uS_IN;
  logic REQ0_IN;
  logic REQ1_IN;
  logic GNT0_OUT;
  logic GNT1_OUT;
  logic SCL0_IN;
  logic SDA0_IN;
  logic SDAT0_IN;
  logic SCL1_IN;
  logic SDA1_IN;
  logic SDAT1_IN;
  logic SDA0_OUT;
  logic SDA1_OUT;
  logic M24C08_SCL_OUT;
  logic M24C08_SDA_OUT;
  logic M24C08_SDAT_OUT;
  logic M24C08_SDA_IN;
  logic BUSY_OUT;
  logic TIMEOUT_OUT;

  modport slave (
    input  PULSE5uS_IN,
    input  REQ0_IN, REQ1_IN,
    input  SCL0_IN, SDA0_IN, SDAT0_IN,
    input  SCL1_IN, SDA1_IN, SDAT1_IN,
    input  M24C08_SDA_IN,
    output GNT0_OUT, GNT1_OUT,
    output SDA0_OUT, SDA1_OUT,
    output M24C08_SCL_OUT, M24C08_SDA_OUT, M24C08_SDAT_OUT,
    output BUSY_OUT, TIMEOUT_OUT
  );

  modport master (
    output PULSE5uS_IN,
    output REQ0_IN, REQ1_IN,
    output SCL0_IN, SDA0_IN, SDAT0_IN,
    output SCL1_IN, SDA1_IN, SDAT1_IN,
    output M24C08_SDA_IN,
    input  GNT0_OUT, GNT1_OUT,
    input  SDA0_OUT, SDA1_OUT,
    input  M24C08_SCL_OUT, M24C08_SDA_OUT, M24C08_SDAT_OUT,
    input  BUSY_OUT, TIMEOUT_OUT
  );
endinterface : m24_bus_arbiter_if

// File: rtl/m24_bus_arbiter.sv
// -----------------------------------------------------------------------------
// m24_bus_arbiter
//
// Shares the single M24C08 I2C pin set between two requesters:
//   requester 0 - boot-time EEPROM reader (GNT0_OUT inverted forms its reset)
//   requester 1 - runtime EEPROM access engine
//
// The bus is granted to one requester at a time, with every state change
// taken on a 5 us tick. While granted, the requester's SCL/SDA/SDAT drives
// are registered onto the physical pins (one SYSCLK cycle of lag). After
// every release an I2C bus-free gap of GAP_TICKS ticks is inserted, and a
// grant held for HOLD_LIMIT ticks is revoked by the watchdog.
//
// Optional feature (compile-time macro M24_ARB_RECOVERY_EN):
//   defined     - a watchdog expiry runs a bus recovery sequence (9 SCL
//                 clocks with SDA released, then a STOP) before the gap.
//   not defined - the recovery state and its tick counter are absent;
//                 expiry goes straight to the gap with the pins idle.
//
// Parameters:
//   HOLD_LIMIT  maximum grant length in ticks, 0 disables the watchdog
//   GAP_TICKS   bus-free ticks after every release, legal range 1..15
//
// Ports:
//   SYSCLK_IN   system clock, all logic on the rising edge
//   RESET_IN    synchronous, active-high reset
//   bus         m24_bus_arbiter_if.slave (requests, grants, pins, status)
// -----------------------------------------------------------------------------
module m24_bus_arbiter #(
  parameter logic [15:0] HOLD_LIMIT = 16'd8192,
  parameter logic [3:0]  GAP_TICKS  = 4'd2
) (
  input logic              SYSCLK_IN,
  input logic              RESET_IN,
  m24_bus_arbiter_if.slave bus
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_GRANT0  = 3'd1;
  localparam logic [2:0] ST_GRANT1  = 3'd2;
  localparam logic [2:0] ST_RECOVER = 3'd3;
  localparam logic [2:0] ST_GAP     = 3'd4;

`ifdef M24_ARB_RECOVERY_EN
  // Recovery tick indices: 0..17 clock SCL, 18 pulls SDA low, 19 raises
  // SCL, 20 releases SDA (STOP).
  localparam logic [4:0] REC_CLK_END  = 5'd18;
  localparam logic [4:0] REC_SCL_HIGH = 5'd19;
  localparam logic [4:0] REC_LAST     = 5'd20;
`endif

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [2:0]  state_q,    state_d;
  logic [15:0] hold_cnt_q, hold_cnt_d;
  logic [3:0]  gap_cnt_q,  gap_cnt_d;
  logic        last_q,     last_d;      // last served requester (0 or 1)
  logic        timeout_q,  timeout_d;
  logic        gnt0_q,     gnt0_d;
  logic        gnt1_q,     gnt1_d;
  logic        scl_q,      scl_d;
  logic        sda_q,      sda_d;
  logic        sdat_q,     sdat_d;
`ifdef M24_ARB_RECOVERY_EN
  logic [4:0]  rec_cnt_q,  rec_cnt_d;
`endif

  logic        tick;
  logic        req_cur;
  logic [15:0] hold_inc;
  logic        hold_expired;

  assign tick = bus.PULSE5uS_IN;

  // Request of whichever requester currently owns the bus.
  assign req_cur = (state_q == ST_GRANT0) ? bus.REQ0_IN : bus.REQ1_IN;

  // Hold counter value after this tick's increment, saturating at all-ones.
  // The watchdog fires on the tick that brings the count up to the limit, so
  // a grant never lasts longer than HOLD_LIMIT ticks.
  assign hold_inc     = (hold_cnt_q == 16'hFFFF) ? hold_cnt_q : hold_cnt_q + 16'd1;
  assign hold_expired = (HOLD_LIMIT != 16'd0) && (hold_inc == HOLD_LIMIT);

  // ---------------------------------------------------------------------------
  // Next-state logic: every transition happens on a tick.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable written here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    last_d     = last_q;
    timeout_d  = 1'b0;
`ifdef M24_ARB_RECOVERY_EN
    rec_cnt_d  = rec_cnt_q;
`endif

    if (tick) begin
      case (state_q)
        ST_IDLE: begin
          // With both requests high, the requester not served last wins.
          if (bus.REQ0_IN && (!bus.REQ1_IN || last_q)) begin
            state_d    = ST_GRANT0;
            hold_cnt_d = 16'd0;
          end else if (bus.REQ1_IN) begin
            state_d    = ST_GRANT1;
            hold_cnt_d = 16'd0;
          end
        end

        ST_GRANT0, ST_GRANT1: begin
          hold_cnt_d = hold_inc;
          if (!req_cur) begin
            // A normal release takes priority over a coincident expiry.
            state_d   = ST_GAP;
            gap_cnt_d = GAP_TICKS;
            last_d    = (state_q == ST_GRANT1);
          end else if (hold_expired) begin
            timeout_d = 1'b1;
            last_d    = (state_q == ST_GRANT1);
`ifdef M24_ARB_RECOVERY_EN
            state_d   = ST_RECOVER;
            rec_cnt_d = 5'd0;
`else
            state_d   = ST_GAP;
            gap_cnt_d = GAP_TICKS;
`endif
          end
        end

`ifdef M24_ARB_RECOVERY_EN
        ST_RECOVER: begin
          if (rec_cnt_q == REC_LAST) begin
            state_d   = ST_GAP;
            gap_cnt_d = GAP_TICKS;
          end else begin
            rec_cnt_d = rec_cnt_q + 5'd1;
          end
        end
`endif

        ST_GAP: begin
          // Requests are ignored here; a re-raised request waits for IDLE,
          // where the round-robin pointer favours the other requester.
          if (gap_cnt_q <= 4'd1) begin
            state_d = ST_IDLE;
          end else begin
            gap_cnt_d = gap_cnt_q - 4'd1;
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Registered outputs, decoded from the next state so grants and pins change
  // on the edge that ends the deciding tick.
  // ---------------------------------------------------------------------------
  always_comb begin
    gnt0_d = (state_d == ST_GRANT0);
    gnt1_d = (state_d == ST_GRANT1);
    scl_d  = 1'b1;
    sda_d  = 1'b1;
    sdat_d = 1'b1;

    case (state_d)
      ST_GRANT0: begin
        scl_d  = bus.SCL0_IN;
        sda_d  = bus.SDA0_IN;
        sdat_d = bus.SDAT0_IN;
      end
      ST_GRANT1: begin
        scl_d  = bus.SCL1_IN;
        sda_d  = bus.SDA1_IN;
        sdat_d = bus.SDAT1_IN;
      end
`ifdef M24_ARB_RECOVERY_EN
      ST_RECOVER: begin
        if (rec_cnt_d < REC_CLK_END) begin
          // Even ticks low, odd ticks high: nine clocks starting low.
          scl_d = rec_cnt_d[0];
        end else if (rec_cnt_d == REC_CLK_END) begin
          scl_d  = 1'b0;
          sda_d  = 1'b0;
          sdat_d = 1'b0;
        end else if (rec_cnt_d == REC_SCL_HIGH) begin
          sda_d  = 1'b0;
          sdat_d = 1'b0;
        end
      end
`endif
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge SYSCLK_IN) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (RESET_IN) begin
      state_q    <= ST_IDLE;
      hold_cnt_q <= 16'd0;
      gap_cnt_q  <= 4'd0;
      last_q     <= 1'b1;
      timeout_q  <= 1'b0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      scl_q      <= 1'b1;
      sda_q      <= 1'b1;
      sdat_q     <= 1'b1;
`ifdef M24_ARB_RECOVERY_EN
      rec_cnt_q  <= 5'd0;
`endif
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      last_q     <= last_d;
      timeout_q  <= timeout_d;
      gnt0_q     <= gnt0_d;
      gnt1_q     <= gnt1_d;
      scl_q      <= scl_d;
      sda_q      <= sda_d;
      sdat_q     <= sdat_d;
`ifdef M24_ARB_RECOVERY_EN
      rec_cnt_q  <= rec_cnt_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.GNT0_OUT        = gnt0_q;
  assign bus.GNT1_OUT        = gnt1_q;
  assign bus.M24C08_SCL_OUT  = scl_q;
  assign bus.M24C08_SDA_OUT  = sda_q;
  assign bus.M24C08_SDAT_OUT = sdat_q;
  assign bus.BUSY_OUT        = (state_q != ST_IDLE);
  assign bus.TIMEOUT_OUT     = timeout_q;

  // A requester only sees the real pin while it owns the bus.
  assign bus.SDA0_OUT = gnt0_q ? bus.M24C08_SDA_IN : 1'b1;
  assign bus.SDA1_OUT = gnt1_q ? bus.M24C08_SDA_IN : 1'b1;

endmodule : m24_bus_arbiter

// File: doc/m24_bus_arbiter.md
# m24_bus_arbiter

Shares the single M24C08 I2C pin set (SCL, SDA, SDA tristate) between two requesters: requester 0 is the boot-time EEPROM reader, requester 1 is the runtime EEPROM access engine. It grants the bus to one requester at a time on 5 µs tick boundaries and registers the granted requester's pin drives onto the physical pins. It enforces an I2C bus-free gap between owners and revokes a grant that exceeds a hold limit. It sits between the EEPROM engines and the top-level IOBUF; GNT0_OUT is inverted to form the reader's reset.

## Interface
- HOLD_LIMIT, 16'd8192: maximum grant length in PULSE5uS_IN ticks; 0 disables the watchdog.
- GAP_TICKS, 4'd2: bus-free ticks inserted after every release; legal range 1–15.
- SYSCLK_IN  input  1  system clock, all logic on rising edge
- RESET_IN  input  1  synchronous, active-high reset
- PULSE5uS_IN  input  1  one-cycle tick every 5 µs
- REQ0_IN / REQ1_IN  input  1  bus request, level, held for the whole transaction
- GNT0_OUT / GNT1_OUT  output  1  bus grant, level, never both high
- SCL0_IN, SDA0_IN, SDAT0_IN / SCL1_IN, SDA1_IN, SDAT1_IN  input  1 each  requester pin drives (SDAT = 1 releases SDA)
- SDA0_OUT / SDA1_OUT  output  1  pin SDA to requester; forced 1 when not granted
- M24C08_SCL_OUT  output  1  SCL pin
- M24C08_SDA_OUT  output  1  SDA output value
- M24C08_SDAT_OUT  output  1  SDA tristate control, 1 = released
- M24C08_SDA_IN  input  1  SDA pin value
- BUSY_OUT  output  1  high in any state other than IDLE
- TIMEOUT_OUT  output  1  one-cycle pulse on watchdog expiry

## Operation
- States: IDLE, GRANT0, GRANT1, RECOVER, GAP. All transitions are evaluated only on cycles with PULSE5uS_IN = 1.
- Reset values: state IDLE, SCL/SDA/SDAT = 1/1/1, GNT0/GNT1 = 0, BUSY = 0, TIMEOUT = 0, hold counter 0, last-served pointer = 1, so requester 0 wins first.
- IDLE: the pins idle at 1/1/1. If only one request is high, it is granted. If both are high, the requester not last served is granted (round robin).
- GRANTn: every cycle, the pins register SCLn/SDAn/SDATn. The hold counter (16 bits) increments per tick, saturating, and is cleared on grant entry.
  - REQn low at a tick → GAP. The pointer is set to n.
  - Hold counter == HOLD_LIMIT, with HOLD_LIMIT ≠ 0 → TIMEOUT_OUT pulses and GNTn drops. The next state is RECOVER, or GAP when recovery is compiled out. The pointer is set to n.
- RECOVER: a fixed 21-tick sequence with the pins registered by the arbiter.
  - Ticks 0–17: SDAT = 1 and SCL toggles low/high, giving 9 clocks that start with SCL low.
  - Tick 18: SCL = 0, SDA = 0, SDAT = 0.
  - Tick 19: SCL = 1.
  - Tick 20: SDA = 1, SDAT = 1 (STOP).
  - Then → GAP.
- GAP: the pins idle at 1/1/1 for GAP_TICKS ticks, then → IDLE. A request that drops during GAP is ignored. Both grants stay 0.
- A requester that drops its request and re-raises it in the same GAP must wait for IDLE. If the other requester is pending, the other one is served first.
- SDAn_OUT = M24C08_SDA_IN while GNTn is high, else 1.

## Timing
- GNTn rises the cycle after the tick on which IDLE sampled the request, so grant latency is ≤ 1 tick + 1 cycle.
- The pin outputs lag the requester drives by exactly one SYSCLK cycle while granted.
- GNTn falls the cycle after the release or timeout tick. The pins return to idle on that same cycle, except in RECOVER, where tick 0 drives SCL = 0 on that cycle.
- Minimum bus-free time between owners is GAP_TICKS × 5 µs.
- Reset mid-grant: all outputs return to reset values on the next edge, with no recovery sequence. The pointer returns to 1.

## Configuration
- M24_ARB_RECOVERY_EN defined: watchdog expiry runs RECOVER (9 SCL clocks + STOP) before GAP.
- Not defined: the RECOVER state and its 5-bit tick counter are absent. Expiry goes directly to GAP, with the pins idling at 1/1/1.

## Test plan
- Reset, then REQ0 held high → GNT0 = 1 one cycle after the first tick. The pins track SCL0/SDA0/SDAT0 with 1-cycle lag, and GNT1 stays 0.
- REQ0 and REQ1 high together from reset → GNT0 first. After REQ0 drops: 2 idle ticks, then GNT1. REQ0 re-raised during GNT1 is granted only after REQ1 drops plus the gap.
- REQ1 alone, released at tick 10 → GNT1 falls, and the pins are 1/1/1 for exactly 2 ticks before IDLE. BUSY_OUT falls at GAP exit.
- HOLD_LIMIT = 16, REQ1 held forever with M24_ARB_RECOVERY_EN → TIMEOUT_OUT pulses once at tick 16. SCL shows 9 low/high pairs and SDA shows low→high with SCL high. Then the gap, after which GNT1 is reasserted.
- Same as the previous scenario without the macro → TIMEOUT pulse, then the pins idle 1/1/1 for 2 ticks, with no SCL toggles.
- RESET_IN asserted mid-GRANT0 → next edge: GNT0 = 0, pins 1/1/1, BUSY = 0. After release with both requests high, requester 0 is granted first.
